pwm_sine_sequencer: RTL and testbench
=====================================

PWM_SINE_SEQUENCER -- requirements
Module: pwm_sine_sequencer

Interface
REQ-001 The block SHALL have one clock, clk_i, and a reset that is asynchronous and active-low, rst_ni.
REQ-002 clk_i  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 enable_i  input  1  level request to run the sine sequence.
REQ-005 speed_i  input  8  PWM periods per phase step, minus 1; range 0..255.
REQ-006 dutycycle_o  output  8  registered duty value for the 256-clock PWM generator.
REQ-007 period_o  output  1  one-cycle registered pulse marking the first clock of each PWM period.
REQ-008 busy_o  output  1  high whenever the state is not IDLE.

Function
REQ-009 Period counter pcnt (8 bit): SHALL increment every clock and wrap from 0xFF to 0x00; period_end = (pcnt == 0xFF).
REQ-010 period_o SHALL be registered high on the edge at which period_end is true, and low otherwise.
REQ-011 dutycycle_o SHALL change only on edges at which period_end is true.
REQ-012 Phase accumulator phase (8 bit), step counter stepcnt (8 bit): phase SHALL wrap from 0xFF to 0x00.
REQ-013 Duty mapping: idx = phase[6] ? ~phase[5:0] : phase[5:0]; q = round(127*sin(pi*(2*idx+1)/256)), giving q(0)=2 and q(63)=127.
REQ-014 Duty mapping: duty = phase[7] ? (127 - q) : (128 + q); the result range SHALL be 0..255 with no overflow.
REQ-015 States: IDLE, RUN, STOPPING; busy_o = (state != IDLE).
REQ-016 IDLE: dutycycle_o=0, phase=0xC0, stepcnt=0; at period_end with enable_i=1 go to RUN, with phase and duty unchanged.
REQ-017 Step rule in RUN/STOPPING at period_end: if stepcnt >= speed_i then phase <= phase+1, stepcnt <= 0 and dutycycle_o <= duty(phase+1); otherwise stepcnt <= stepcnt+1 and duty is held.
REQ-018 Because the step rule uses >=, lowering speed_i mid-count SHALL cause a step at the next period_end.
REQ-019 RUN at period_end with enable_i=0: handling is defined under Configuration.
REQ-020 STOPPING at period_end with enable_i=1: go to RUN and apply the step rule; phase SHALL NOT be reset.
REQ-021 STOPPING at period_end with enable_i=0: apply the step rule; if the resulting phase is 0xC0 (duty 0), go to IDLE.
REQ-022 enable_i and speed_i SHALL be sampled only at period_end; toggles between period ends SHALL have no effect.

Reset
REQ-023 Assertion of rst_ni SHALL immediately (asynchronously) force pcnt=0, phase=0xC0, stepcnt=0, state=IDLE, dutycycle_o=0, period_o=0 and busy_o=0.
REQ-024 Reset mid-sequence SHALL abandon the current phase with no fade.
REQ-025 The first period_end after deassertion SHALL occur 256 clocks later.

Configuration
REQ-026 Macro PWM_SINE_FADE_STOP_EN: when defined, RUN at period_end with enable_i=0 SHALL go to STOPPING and apply the step rule in the same edge.
REQ-027 With PWM_SINE_FADE_STOP_EN defined, if phase is already 0xC0 at that edge, the block SHALL go directly to IDLE instead.
REQ-028 When PWM_SINE_FADE_STOP_EN is undefined, RUN at period_end with enable_i=0 SHALL go to IDLE with dutycycle_o=0, phase=0xC0 and stepcnt=0.
REQ-029 When PWM_SINE_FADE_STOP_EN is undefined, STOPPING SHALL be unreachable.

Verification
REQ-030 Reset release, enable_i=1, speed_i=0: clock 255 -> period_o pulse, busy_o=1, duty 0; after 64 more period ends phase=0x00 and duty=130.
REQ-031 Continue the REQ-030 scenario: phase 0x40 -> duty 255; phase 0x80 -> duty 125; phase 0xC0 -> duty 0; a full sine cycle SHALL take 65536 clocks.
REQ-032 speed_i=3: the phase SHALL step exactly once every 4 period ends (1024 clocks); switching speed_i to 0 when stepcnt=2 SHALL cause a step at the next period_end.
REQ-033 Fade-stop (macro defined): drop enable_i at phase 0x40 -> duty keeps stepping, reaches 0 at phase 0xC0, then IDLE with busy_o=0 (128 steps).
REQ-034 Abrupt stop (macro undefined): drop enable_i at phase 0x40 -> at the next period_end duty=0 and state=IDLE.
REQ-035 Assert rst_ni low mid-period while duty=200: outputs SHALL go to 0 without waiting for a clock, and pcnt SHALL restart from 0.

Source files
------------

// File: rtl/pwm_sine_sequencer_if.sv
// ---------------------------------------------------------------------------
// pwm_sine_sequencer_if
// Purpose : groups the control and status signals of pwm_sine_sequencer.
// Signals :
//   enable_i     level request to run the sine sequence
//   speed_i      PWM periods per phase step, minus 1 (0..255)
//   dutycycle_o  registered duty value for a 256-clock PWM generator
//   period_o     one-cycle pulse on the first clock of each PWM period
//   busy_o       high while the sequencer is not idle
// Modports:
//   master  drives enable_i/speed_i and observes the outputs
//   slave   the sequencer side
// ---------------------------------------------------------------------------
interface pwm_sine_sequencer_if;
  logic       enable_i;
  logic [7:0] speed_i;
  logic [7:0] dutycycle_o;
  logic       period_o;
  logic       busy_o;

  modport master (
    output enable_i,
    output speed_i,
    input  dutycycle_o,
    input  period_o,
    input  busy_o
  );

  modport slave (
    input  enable_i,
    input  speed_i,
    output dutycycle_o,
    output period_o,
    output busy_o
  );
endinterface

// File: rtl/pwm_sine_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_sine_sequencer
// Purpose : steps an 8-bit phase through one sine cycle and publishes the
//           matching duty value once per 256-clock PWM period. The phase
//           advances once every (speed_i + 1) PWM periods while enabled.
// Ports   :
//   clk_i   system clock, all state on the rising edge
//   rst_ni  asynchronous active-low reset
//   seq_if  slave modport of pwm_sine_sequencer_if
//           (enable_i, speed_i in; dutycycle_o, period_o, busy_o out)
// Build option:
//   PWM_SINE_FADE_STOP_EN  when defined, dropping enable_i lets the sine
//                          keep stepping until the duty reaches 0 (phase
//                          0xC0) before going idle; when undefined the
//                          sequencer stops at the next period end.
// ---------------------------------------------------------------------------
module pwm_sine_sequencer (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  pwm_sine_sequencer_if.slave        seq_if
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  // Phase 0xC0 is the trough of the sine: duty 0. Idle parks here.
  localparam logic [7:0] PHASE_REST = 8'hC0;

  // Quarter-wave table: round(127*sin(pi*(2*idx+1)/256)), idx = 0..63.
  // The half-sample offset keeps the curve symmetric about both quarter
  // boundaries, so mirroring idx needs no special cases.
  localparam logic [6:0] SINE_Q [0:63] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  // Full-wave duty from phase: phase[6] mirrors the quarter, phase[7]
  // selects the lower half. Range is 0..255 by construction (q <= 127).
  function automatic logic [7:0] sine_duty(input logic [7:0] phase);
    logic [5:0] idx;
    logic [7:0] q;
    idx = phase[6] ? ~phase[5:0] : phase[5:0];
    q   = {1'b0, SINE_Q[idx]};
    return phase[7] ? (8'd127 - q) : (8'd128 + q);
  endfunction

  state_t     r_state;
  logic [7:0] r_pcnt;
  logic [7:0] r_phase;
  logic [7:0] r_stepcnt;
  logic [7:0] r_duty;
  logic       r_period;

  logic       w_period_end;
  logic       w_step;
  logic [7:0] w_phase_inc;
  logic [7:0] w_step_phase;
  logic [7:0] w_step_cnt;
  logic [7:0] w_step_duty;

  assign w_period_end = (r_pcnt == 8'hFF);

  // '>=' rather than '==' so a speed_i lowered below the running count
  // steps at the very next period end instead of wrapping stepcnt.
  assign w_step       = (r_stepcnt >= seq_if.speed_i);
  assign w_phase_inc  = r_phase + 8'd1;

  // Outcome of the step rule, used by every running state.
  // stepcnt < speed_i <= 255 when not stepping, so +1 cannot overflow.
  assign w_step_phase = w_step ? w_phase_inc            : r_phase;
  assign w_step_cnt   = w_step ? 8'd0                   : r_stepcnt + 8'd1;
  assign w_step_duty  = w_step ? sine_duty(w_phase_inc) : r_duty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_pcnt    <= 8'd0;
      r_phase   <= PHASE_REST;
      r_stepcnt <= 8'd0;
      r_duty    <= 8'd0;
      r_period  <= 1'b0;
    end else begin
      r_pcnt   <= r_pcnt + 8'd1;
      r_period <= w_period_end;

      // enable_i and speed_i only matter here, once per PWM period.
      if (w_period_end) begin
        case (r_state)
          ST_IDLE: begin
            if (seq_if.enable_i) begin
              r_state <= ST_RUN;
            end
          end

          ST_RUN: begin
            if (seq_if.enable_i) begin
              r_phase   <= w_step_phase;
              r_stepcnt <= w_step_cnt;
              r_duty    <= w_step_duty;
            end else begin
`ifdef PWM_SINE_FADE_STOP_EN
              // Already at (or stepping onto) the trough: nothing left to
              // fade, so park directly rather than loop a whole cycle.
              if ((r_phase == PHASE_REST) || (w_step_phase == PHASE_REST)) begin
                r_state   <= ST_IDLE;
                r_phase   <= PHASE_REST;
                r_stepcnt <= 8'd0;
                r_duty    <= 8'd0;
              end else begin
                r_state   <= ST_STOPPING;
                r_phase   <= w_step_phase;
                r_stepcnt <= w_step_cnt;
                r_duty    <= w_step_duty;
              end
`else
              r_state   <= ST_IDLE;
              r_phase   <= PHASE_REST;
              r_stepcnt <= 8'd0;
              r_duty    <= 8'd0;
`endif
            end
          end

          ST_STOPPING: begin
            r_phase   <= w_step_phase;
            r_stepcnt <= w_step_cnt;
            r_duty    <= w_step_duty;
            if (seq_if.enable_i) begin
              r_state <= ST_RUN;
            end else if (w_step_phase == PHASE_REST) begin
              r_state   <= ST_IDLE;
              r_stepcnt <= 8'd0;
              r_duty    <= 8'd0;
            end
          end

          default: begin
            r_state   <= ST_IDLE;
            r_phase   <= PHASE_REST;
            r_stepcnt <= 8'd0;
            r_duty    <= 8'd0;
          end
        endcase
      end
    end
  end

  assign seq_if.dutycycle_o = r_duty;
  assign seq_if.period_o    = r_period;
  assign seq_if.busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pwm_sine_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pwm_sine_sequencer
// Directed bench for pwm_sine_sequencer. Expected duty values are taken
// from the hand-evaluated sine mapping at the phases visited.
// ---------------------------------------------------------------------------
module tb_pwm_sine_sequencer;

  logic clk_i = 1'b0;
  logic rst_ni;

  pwm_sine_sequencer_if bus ();

  pwm_sine_sequencer dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .seq_if (bus)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called on the sampling edge right after a period pulse; moves forward
  // n whole PWM periods and confirms the pulse is there again.
  task automatic advance(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      repeat (256) @(negedge clk_i);
    end
    chk({tag, "_period"}, {7'd0, bus.period_o}, 8'd1);
  endtask

  initial begin
    rst_ni       = 1'b0;
    bus.enable_i = 1'b0;
    bus.speed_i  = 8'd0;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_duty",   bus.dutycycle_o,        8'd0);
    chk("rst_period", {7'd0, bus.period_o},   8'd0);
    chk("rst_busy",   {7'd0, bus.busy_o},     8'd0);

    // Release with enable high; first period end after 256 clocks
    bus.enable_i = 1'b1;
    rst_ni       = 1'b1;
    repeat (255) @(negedge clk_i);
    chk("pe1_early_period", {7'd0, bus.period_o}, 8'd0);
    chk("pe1_early_busy",   {7'd0, bus.busy_o},   8'd0);
    @(negedge clk_i);
    chk("pe1_period", {7'd0, bus.period_o}, 8'd1);
    chk("pe1_busy",   {7'd0, bus.busy_o},   8'd1);
    chk("pe1_duty",   bus.dutycycle_o,      8'd0);
    @(negedge clk_i);
    chk("pe1_pulse_width", {7'd0, bus.period_o}, 8'd0);
    repeat (254) @(negedge clk_i);
    // PE2: first step, phase 0xC1 -> duty 0
    @(negedge clk_i);
    chk("pe2_period", {7'd0, bus.period_o}, 8'd1);
    chk("c1_duty",    bus.dutycycle_o,      8'd0);

    // 63 more steps: phase 0x00 -> 128+2
    advance(63, "p00");
    chk("p00_duty", bus.dutycycle_o, 8'd130);

    // Mid-period: duty held, enable glitch and new speed not yet sampled
    repeat (100) @(negedge clk_i);
    chk("p00_hold_duty",   bus.dutycycle_o,      8'd130);
    chk("p00_hold_period", {7'd0, bus.period_o}, 8'd0);
    bus.speed_i  = 8'd3;
    bus.enable_i = 1'b0;
    repeat (50) @(negedge clk_i);
    bus.enable_i = 1'b1;
    repeat (106) @(negedge clk_i);
    chk("spd3_a_period", {7'd0, bus.period_o}, 8'd1);
    chk("spd3_a_busy",   {7'd0, bus.busy_o},   8'd1);
    chk("spd3_a_duty",   bus.dutycycle_o,      8'd130);

    // stepcnt 1 -> 3: still no step; fourth period end steps to 0x01
    advance(2, "spd3_b");
    chk("spd3_b_duty", bus.dutycycle_o, 8'd130);
    advance(1, "p01");
    chk("p01_duty", bus.dutycycle_o, 8'd133);

    // Two periods in (stepcnt=2), drop speed to 0: step at next period end
    advance(2, "spd3_c");
    chk("spd3_c_duty", bus.dutycycle_o, 8'd133);
    repeat (128) @(negedge clk_i);
    bus.speed_i = 8'd0;
    repeat (128) @(negedge clk_i);
    chk("p02_period", {7'd0, bus.period_o}, 8'd1);
    chk("p02_duty",   bus.dutycycle_o,      8'd136);

    // Phase 0x18: idx 24, q 72 -> duty 200
    advance(22, "p18");
    chk("p18_duty", bus.dutycycle_o, 8'd200);

    // Asynchronous reset mid-period, away from any clock edge
    repeat (100) @(negedge clk_i);
    chk("p18_hold_duty", bus.dutycycle_o, 8'd200);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_duty",   bus.dutycycle_o,      8'd0);
    chk("arst_period", {7'd0, bus.period_o}, 8'd0);
    chk("arst_busy",   {7'd0, bus.busy_o},   8'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Period counter restarted: pulse again exactly 256 clocks later
    repeat (255) @(negedge clk_i);
    chk("rel_early_period", {7'd0, bus.period_o}, 8'd0);
    @(negedge clk_i);
    chk("rel_period", {7'd0, bus.period_o}, 8'd1);
    chk("rel_busy",   {7'd0, bus.busy_o},   8'd1);
    chk("rel_duty",   bus.dutycycle_o,      8'd0);
    advance(1, "r_c1");
    chk("r_c1_duty", bus.dutycycle_o, 8'd0);

    // Phase 0xD0: idx 47, q 117 -> 127-117
    advance(15, "pd0");
    chk("pd0_duty", bus.dutycycle_o, 8'd10);
    advance(48, "r_p00");
    chk("r_p00_duty", bus.dutycycle_o, 8'd130);
    advance(32, "p20");
    chk("p20_duty", bus.dutycycle_o, 8'd219);
    advance(32, "p40");
    chk("p40_duty", bus.dutycycle_o, 8'd255);

    // Drop enable at phase 0x40
    repeat (128) @(negedge clk_i);
    bus.enable_i = 1'b0;
    repeat (128) @(negedge clk_i);
    chk("stop_period", {7'd0, bus.period_o}, 8'd1);
`ifdef PWM_SINE_FADE_STOP_EN
    chk("fade_p41_duty", bus.dutycycle_o,    8'd255);
    chk("fade_p41_busy", {7'd0, bus.busy_o}, 8'd1);
    advance(7, "fade_p48");
    chk("fade_p48_duty", bus.dutycycle_o, 8'd252);
    advance(56, "fade_p80");
    chk("fade_p80_duty", bus.dutycycle_o,    8'd125);
    chk("fade_p80_busy", {7'd0, bus.busy_o}, 8'd1);
    advance(32, "fade_pa0");
    chk("fade_pa0_duty", bus.dutycycle_o, 8'd36);
    advance(31, "fade_pbf");
    chk("fade_pbf_duty", bus.dutycycle_o,    8'd0);
    chk("fade_pbf_busy", {7'd0, bus.busy_o}, 8'd1);
    advance(1, "fade_pc0");
    chk("fade_pc0_duty", bus.dutycycle_o,    8'd0);
    chk("fade_pc0_busy", {7'd0, bus.busy_o}, 8'd0);
`else
    chk("abrupt_duty", bus.dutycycle_o,    8'd0);
    chk("abrupt_busy", {7'd0, bus.busy_o}, 8'd0);
`endif
    advance(1, "idle_hold");
    chk("idle_hold_duty", bus.dutycycle_o,    8'd0);
    chk("idle_hold_busy", {7'd0, bus.busy_o}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
